// File: rtl/cpu_trace_unit.sv
// cpu_trace_unit
// Snoops the monocycle CPU's register-file write port and PC, storing every
// write event as {pc, wa3, wd3} in a circular trace buffer. Capture stops on a
// PC trigger (plus a post-trigger window of writes), on a cycle budget, or when
// run drops. Once done, the buffer is read out oldest-first, one entry per
// cycle, through a request/valid port. Nothing is driven back into the CPU.
//
// Ports:
//   clk        system clock, rising edge
//   start      synchronous active-low reset
//   run        capture enable (level)
//   pc         CPU program counter this cycle
//   we3/wa3/wd3 CPU register-file write port
//   trig_en    enables the PC trigger
//   trig_pc    PC value that fires the trigger
//   rd_req     readout request, one entry per cycle while high
//   rd_data    readout entry {pc, wa3, wd3}
//   rd_valid   rd_data holds a fresh entry this cycle
//   rd_empty   no unread entries left (meaningful once done)
//   count      stored entries, saturating at DEPTH
//   wrapped    at least one entry was overwritten
//   triggered  PC trigger matched
//   timeout    cycle budget exhausted
//   done       capture finished, readout allowed
module cpu_trace_unit #(
  parameter int PC_W       = 10,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 64,
  parameter int POST_TRIG  = 4
) (
  input  logic                           clk,
  input  logic                           start,
  input  logic                           run,
  input  logic [PC_W-1:0]                pc,
  input  logic                           we3,
  input  logic [3:0]                     wa3,
  input  logic [DATA_W-1:0]              wd3,
  input  logic                           trig_en,
  input  logic [PC_W-1:0]                trig_pc,
  input  logic                           rd_req,
  output logic [PC_W+4+DATA_W-1:0]       rd_data,
  output logic                           rd_valid,
  output logic                           rd_empty,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           wrapped,
  output logic                           triggered,
  output logic                           timeout,
  output logic                           done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = PC_W + 4 + DATA_W;
  localparam int CYW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
  localparam int PW  = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);
  localparam int PW1 = PW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_POST    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]     state, state_nxt;
  logic [AW-1:0]  wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [CW-1:0]  count_nxt, unread;
  logic [CYW-1:0] cyc_cnt;
  logic [PW-1:0]  post_cnt;
  logic [EW-1:0]  mem [DEPTH];

  logic active, cap, last_cycle, trig_hit, post_last, full, enter_done;

  // active: a capture-phase cycle that is not being aborted.
  assign active     = ((state == S_CAPTURE) || (state == S_POST)) && run;
  assign cap        = active && we3;
  assign full       = (count == CW'(DEPTH));
  assign last_cycle = (cyc_cnt == CYW'(MAX_CYCLES - 1));
  // Trigger is only armed before it has fired, i.e. in CAPTURE.
  assign trig_hit   = (state == S_CAPTURE) && run && trig_en && (pc == trig_pc);
  assign post_last  = (state == S_POST) && cap &&
                      (({1'b0, post_cnt} + PW1'(1)) == PW1'(POST_TRIG));

  assign count_nxt  = (cap && !full) ? count + CW'(1) : count;
  assign wr_ptr_nxt = cap ? wr_ptr + AW'(1) : wr_ptr;
  assign enter_done = (state != S_DONE) && (state_nxt == S_DONE);
  assign rd_empty   = (unread == '0);

  // Next-state selection; abort (run low) takes precedence over everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (!run || last_cycle)
          state_nxt = S_DONE;
        else if (trig_hit)
          state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
      end
      S_POST:    if (!run || last_cycle || post_last) state_nxt = S_DONE;
      default:   state_nxt = S_DONE;
    endcase
  end

  // Trace storage has no reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (start && cap)
      mem[wr_ptr] <= {pc, wa3, wd3};
  end

  // Control, flags and readout. On the transition into DONE the read pointer
  // is placed at the oldest entry: the write pointer if the buffer filled up,
  // otherwise slot zero.
  always_ff @(posedge clk) begin
    if (!start) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      unread    <= '0;
      cyc_cnt   <= '0;
      post_cnt  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      done     <= (state_nxt == S_DONE);
      rd_valid <= 1'b0;

      if (cap && full)
        wrapped <= 1'b1;

      if (state == S_IDLE)
        cyc_cnt <= '0;
      else if (active)
        cyc_cnt <= cyc_cnt + CYW'(1);

      if (active && last_cycle)
        timeout <= 1'b1;

      if (trig_hit) begin
        triggered <= 1'b1;
        post_cnt  <= '0;
      end else if ((state == S_POST) && cap) begin
        post_cnt  <= post_cnt + PW'(1);
      end

      if (enter_done) begin
        rd_ptr <= (count_nxt == CW'(DEPTH)) ? wr_ptr_nxt : '0;
        unread <= count_nxt;
      end else if ((state == S_DONE) && rd_req && (unread != '0)) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
        unread   <= unread - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_unit.sv
// tb_cpu_trace_unit
// Self-checking bench for cpu_trace_unit: a table of cycle vectors for the
// basic capture/readout flow, hand-written sequences for wrap, trigger window,
// timeout, reset-in-POST and trigger-on-last-cycle, then randomized captures
// compared against a queue-based reference model.
module tb_cpu_trace_unit;

  localparam int PC_W       = 10;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 16;
  localparam int MAX_CYCLES = 64;
  localparam int POST_TRIG  = 4;
  localparam int EW         = PC_W + 4 + DATA_W;

  logic              clk = 1'b0;
  logic              start = 1'b0;
  logic              run = 1'b0;
  logic [PC_W-1:0]   pc = '0;
  logic              we3 = 1'b0;
  logic [3:0]        wa3 = '0;
  logic [DATA_W-1:0] wd3 = '0;
  logic              trig_en = 1'b0;
  logic [PC_W-1:0]   trig_pc = '0;
  logic              rd_req = 1'b0;
  logic [EW-1:0]     rd_data;
  logic              rd_valid, rd_empty, wrapped, triggered, timeout, done;
  logic [4:0]        count;

  int checks = 0;
  int failures = 0;

  cpu_trace_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .MAX_CYCLES(MAX_CYCLES), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .start(start), .run(run), .pc(pc), .we3(we3), .wa3(wa3),
    .wd3(wd3), .trig_en(trig_en), .trig_pc(trig_pc), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .count(count), .wrapped(wrapped), .triggered(triggered),
    .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          run, we3;
    logic [3:0]    wa3;
    logic [7:0]    wd3;
    logic [9:0]    pc;
    logic          rd_req;
    logic          e_done;
    logic [4:0]    e_count;
    logic          e_valid, e_empty, e_wrapped;
    logic [EW-1:0] e_data;
  } vec_t;

  vec_t vecs [13];

  // Reference model state
  bit            m_started, m_stopped, m_trig, m_tmo, m_wrap;
  int            m_cycles, m_postLeft;
  logic [EW-1:0] m_q [$];

  function automatic logic [EW-1:0] ent(input int p, input int a, input int d);
    return {10'(p), 4'(a), 8'(d)};
  endfunction

  function automatic vec_t mkVec(input logic r, w, input int a, d, p,
                                 input logic q, ed, input int ec,
                                 input logic ev, ee, ew, input logic [EW-1:0] edata);
    vec_t v;
    v.run = r; v.we3 = w; v.wa3 = 4'(a); v.wd3 = 8'(d); v.pc = 10'(p);
    v.rd_req = q; v.e_done = ed; v.e_count = 5'(ec); v.e_valid = ev;
    v.e_empty = ee; v.e_wrapped = ew; v.e_data = edata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, step one clock, settle just after it.
  task automatic applyStimulus(input logic r, w, input logic [3:0] a,
                               input logic [7:0] d, input logic [9:0] p, input logic q);
    run = r; we3 = w; wa3 = a; wd3 = d; pc = p; rd_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    start = 1'b0; run = 1'b0; we3 = 1'b0; rd_req = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " rd_data"}, 32'(rd_data), 32'd0);
    checkOutput({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, " rd_empty"}, 32'(rd_empty), 32'd1);
    checkOutput({tag, " count"}, 32'(count), 32'd0);
    checkOutput({tag, " flags"}, {28'd0, wrapped, triggered, timeout, done}, 32'd0);
  endtask

  task automatic modelReset();
    m_started = 0; m_stopped = 0; m_trig = 0; m_tmo = 0; m_wrap = 0;
    m_cycles = 0; m_postLeft = 0;
    m_q.delete();
  endtask

  // One clock of the trace rules, computed from what the cycle's inputs mean.
  task automatic modelStep(input logic r, w, input logic [3:0] a,
                           input logic [7:0] d, input logic [9:0] p);
    bit inPost;
    if (!m_started) begin
      if (r) m_started = 1;
      return;
    end
    if (m_stopped) return;
    if (!r) begin
      m_stopped = 1;
      return;
    end
    inPost = m_trig;
    if (w) begin
      m_q.push_back({p, a, d});
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_wrap = 1;
      end
      if (inPost) m_postLeft--;
    end
    m_cycles++;
    if (!inPost && trig_en && (p == trig_pc)) begin
      m_trig = 1;
      m_postLeft = POST_TRIG;
    end
    if (m_cycles == MAX_CYCLES) begin
      m_tmo = 1;
      m_stopped = 1;
    end
    if (m_trig && (m_postLeft == 0)) m_stopped = 1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [EW-1:0] lastData;
    int n;

    // Table: 5 writes, abort, 5 reads, one read past empty.
    vecs[0] = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
    for (int i = 1; i <= 5; i++)
      vecs[i] = mkVec(1, 1, i, 8'h10 + i - 1, i - 1, 0, 0, i, 0, 1, 0, '0);
    vecs[6] = mkVec(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++)
      vecs[7 + k] = mkVec(0, 0, 0, 0, 0, 1, 1, 5, 1, (k == 4), 0, ent(k, k + 1, 8'h10 + k));
    vecs[12] = mkVec(0, 0, 0, 0, 0, 1, 1, 5, 0, 1, 0, ent(4, 5, 8'h14));

    doReset();
    checkReset("reset");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].run, vecs[i].we3, vecs[i].wa3, vecs[i].wd3, vecs[i].pc, vecs[i].rd_req);
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
      checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
      checkOutput($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d rd_empty", i), 32'(rd_empty), 32'(vecs[i].e_empty));
      checkOutput($sformatf("vec%0d wrapped", i), 32'(wrapped), 32'(vecs[i].e_wrapped));
      checkOutput($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
    end

    // Wrap: 20 writes into 16 slots, oldest surviving entry is write 4.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 4'(i), 8'(i), 10'(i), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("wrap count", 32'(count), 32'd16);
    checkOutput("wrap wrapped", 32'(wrapped), 32'd1);
    checkOutput("wrap done", 32'(done), 32'd1);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("wrap read%0d", k), {31'd0, rd_valid} << 31 | 32'(rd_data),
                  32'h8000_0000 | 32'(ent(4 + k, 4 + k, 4 + k)));
    end

    // Trigger at pc 7 followed by four post-trigger writes.
    doReset();
    trig_en = 1'b1; trig_pc = 10'd7;
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(1, 1, 4'(c), 8'(c), 10'(c), 0);
      if (c == 10) checkOutput("trig done before pc11", 32'(done), 32'd0);
    end
    checkOutput("trig done after pc11", 32'(done), 32'd1);
    checkOutput("trig triggered", 32'(triggered), 32'd1);
    checkOutput("trig timeout", 32'(timeout), 32'd0);
    applyStimulus(1, 1, 4'd12, 8'd12, 10'd12, 0);
    checkOutput("trig count frozen", 32'(count), 32'd12);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("trig read%0d", k), 32'(rd_data), 32'(ent(k, k, k)));
    end
    trig_en = 1'b0;

    // Timeout: sparse writes, including one in the final budgeted cycle.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < MAX_CYCLES; c++) begin
      applyStimulus(1, (c % 10 == 3) || (c == 63), 4'(c), 8'(c), 10'(c), 0);
      if (c == 62) checkOutput("tmo done at 62", 32'(done), 32'd0);
    end
    checkOutput("tmo done", 32'(done), 32'd1);
    checkOutput("tmo timeout", 32'(timeout), 32'd1);
    checkOutput("tmo triggered", 32'(triggered), 32'd0);
    checkOutput("tmo count", 32'(count), 32'd7);
    for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tmo last entry", 32'(rd_data), 32'(ent(63, 63, 63)));

    // Reset during POST, idle while run low, then a clean new capture.
    doReset();
    trig_en = 1'b1; trig_pc = 10'd2;
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 4; c++) applyStimulus(1, 1, 4'(c), 8'(c), 10'(c), 0);
    checkOutput("post pre-reset triggered", 32'(triggered), 32'd1);
    start = 1'b0;
    applyStimulus(1, 1, 4'd5, 8'd5, 10'd5, 1);
    start = 1'b1;
    checkReset("post reset");
    trig_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'd1, 8'd1, 10'd1, 0);
      checkOutput($sformatf("idle%0d done/count", i), {26'd0, done, count}, 32'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 4'(i + 1), 8'hA0 + 8'(i), 10'(20 + i), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("recap count", 32'(count), 32'd3);
    checkOutput("recap flags", {28'd0, wrapped, triggered, timeout, done}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("recap read0", 32'(rd_data), 32'(ent(20, 1, 8'hA0)));

    // Trigger on the last budgeted cycle: both flags, straight to DONE.
    doReset();
    trig_en = 1'b1; trig_pc = 10'd63;
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < MAX_CYCLES; c++) begin
      applyStimulus(1, (c == 63), 4'(c), 8'(c), 10'(c), 0);
      if (c == 62) checkOutput("last-trig done at 62", 32'(done), 32'd0);
    end
    checkOutput("last-trig flags", {28'd0, wrapped, triggered, timeout, done}, 32'b0111);
    checkOutput("last-trig count", 32'(count), 32'd1);
    trig_en = 1'b0;

    // Randomized captures against the reference model.
    for (int run_i = 0; run_i < 30; run_i++) begin
      logic r, w, q;
      logic [3:0] a;
      logic [7:0] d;
      logic [9:0] p;
      doReset();
      modelReset();
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = 10'($urandom_range(0, 40));
      for (int c = 0; c < 150; c++) begin
        r = (c == 0) ? 1'b1 : ($urandom_range(0, 99) >= 2);
        w = 1'($urandom_range(0, 1));
        a = 4'($urandom);
        d = 8'($urandom);
        p = 10'($urandom_range(0, 40));
        modelStep(r, w, a, d, p);
        applyStimulus(r, w, a, d, p, 0);
        checkOutput($sformatf("rnd%0d c%0d done", run_i, c), 32'(done), 32'(m_stopped));
        if (m_stopped) break;
      end
      checkOutput($sformatf("rnd%0d count", run_i), 32'(count), 32'(m_q.size()));
      checkOutput($sformatf("rnd%0d flags", run_i), {29'd0, wrapped, triggered, timeout},
                  {29'd0, m_wrap, m_trig, m_tmo});
      lastData = '0;
      n = 0;
      while ((m_q.size() > 0 || n == 0) && n < 100) begin
        q = ($urandom_range(0, 3) != 0);
        applyStimulus(0, 1, 0, 0, 0, q);
        if (q && m_q.size() > 0) begin
          lastData = m_q.pop_front();
          checkOutput($sformatf("rnd%0d read valid", run_i), 32'(rd_valid), 32'd1);
        end else begin
          checkOutput($sformatf("rnd%0d idle valid", run_i), 32'(rd_valid), 32'd0);
        end
        checkOutput($sformatf("rnd%0d rd_data", run_i), 32'(rd_data), 32'(lastData));
        n++;
      end
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("rnd%0d drained", run_i), {30'd0, rd_valid, rd_empty}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_unit.md
Name: cpu_trace_unit

Overview:
- Synthesisable, parametrised replacement for the bench-level $monitor/timeout pair around the monocycle cpu.
- Snoops the CPU register-file write port and PC each clock and stores write events in a circular trace buffer.
- Stops on a PC trigger plus post-trigger window, on a cycle budget, or on abort; the buffer is then read out oldest-first through a request/valid port.
- Sits beside cpu in the top level; it drives nothing back into the CPU.

Parameters:
- PC_W, 10, width of snooped program counter.
- DATA_W, 8, width of register write data (wd3).
- DEPTH, 16, trace entries; power of two, ≥2.
- MAX_CYCLES, 64, cycle budget from capture start to forced stop; ≥2.
- POST_TRIG, 4, register writes captured after trigger; 0 means stop on the trigger cycle.

Ports:
- clk  in  1  system clock, rising edge.
- start  in  1  synchronous active-low reset; start==0 at a rising edge resets the block.
- run  in  1  capture enable; level-sensitive.
- pc  in  PC_W  CPU program counter this cycle.
- we3  in  1  CPU register-file write enable.
- wa3  in  4  register-file write address.
- wd3  in  DATA_W  register-file write data.
- trig_en  in  1  enables PC trigger.
- trig_pc  in  PC_W  trigger PC value.
- rd_req  in  1  readout request, one entry per cycle held high.
- rd_data  out  PC_W+4+DATA_W  entry {pc, wa3, wd3}.
- rd_valid  out  1  rd_data valid this cycle.
- rd_empty  out  1  no unread entries (meaningful in DONE).
- count  out  log2(DEPTH)+1  stored entries, saturates at DEPTH.
- wrapped  out  1  at least one entry overwritten.
- triggered  out  1  trigger matched.
- timeout  out  1  cycle budget exhausted.
- done  out  1  capture finished, readout allowed.

Behaviour:
- Reset (start==0 at edge): state IDLE; wr_ptr, rd_ptr, count, cycle counter and post counter cleared; rd_data=0. Flags rd_valid, wrapped, triggered, timeout and done are 0; rd_empty=1. Reset overrides everything, including mid-capture and mid-readout.
- States: IDLE, CAPTURE, POST, DONE.
- IDLE: run==1 → CAPTURE next cycle; nothing captured in the IDLE cycle; cyc_cnt=0.
- CAPTURE/POST capture rule: if we3==1, entry {pc,wa3,wd3} is written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - count increments, saturating at DEPTH.
  - A write while count==DEPTH overwrites the oldest entry and sets wrapped (sticky).
- Cycle budget: cyc_cnt increments every CAPTURE/POST cycle. The cycle in which cyc_cnt==MAX_CYCLES-1 is captured, sets timeout and moves to DONE.
- Trigger: evaluated only in CAPTURE when trig_en==1 and pc==trig_pc.
  - Sets triggered; that cycle's write, if any, is captured.
  - If POST_TRIG==0, next state is DONE; otherwise POST with post_cnt=0.
- POST: each captured write increments post_cnt. The write making post_cnt==POST_TRIG is stored, then next state is DONE. Further trigger matches are ignored.
- Simultaneous trigger and timeout in one cycle: both flags set; DONE.
- Abort: run==0 in CAPTURE/POST moves to DONE next cycle; that cycle's write is not captured.
- DONE:
  - done=1; run and we3 ignored; exit only via reset.
  - On entry, rd_ptr = wr_ptr if count==DEPTH, else 0; unread = count.
- Readout:
  - rd_req==1 in DONE with unread>0 produces, next cycle, rd_valid=1 and rd_data=entry[rd_ptr]; rd_ptr advances modulo DEPTH and unread decrements.
  - rd_req with unread==0 gives rd_valid=0 and rd_data holds its last value.
  - rd_req outside DONE is ignored.
  - rd_empty = (unread==0).
- Latency: capture 0 cycles (write at the edge of the event cycle); readout 1 cycle req→valid.

Test Plan:
- Reset then run=1; 5 writes (wa3=1..5, wd3=8'h10..8'h14, pc=0..4); run=0 → DONE, count=5, wrapped=0; 5 reads return entries in order with wd3 10..14; 6th read gives rd_valid=0 and rd_empty=1.
- DEPTH=16, 20 consecutive writes wd3=0..19, then abort → count=16, wrapped=1; first read wd3=4, last read wd3=19.
- trig_en=1, trig_pc=10'd7, POST_TRIG=4; write every cycle with pc=cycle index → triggered=1; the last stored entry is at pc=11; DONE on the cycle after the pc=11 write.
- run=1 with no trigger and sparse writes → timeout=1, done=1 after exactly 64 CAPTURE cycles; entries written in cycle 63 are present.
- start=0 asserted in POST after 2 post-trigger writes → all outputs return to reset values next cycle. The block stays IDLE while run==0, and a new capture starts cleanly.
- Trigger match on cycle MAX_CYCLES-1 → triggered=1 and timeout=1; DONE without entering POST.
